// File: rtl/window_byte_fifo_if.sv
// Handshake bundle for window_byte_fifo: word input side,
// window output side and occupancy.
interface window_byte_fifo_if #(
  parameter int IN_BYTES  = 8,
  parameter int WIN_BYTES = 3,
  parameter int DEPTH     = 16
);
  localparam int CW = $clog2(DEPTH + 1);

  logic [8*IN_BYTES-1:0]  in_data;
  logic                   in_valid;
  logic                   in_ready;
  logic [8*WIN_BYTES-1:0] win_data;
  logic                   win_valid;
  logic                   win_ready;
  logic [CW-1:0]          count;

  modport master (
    output in_data, in_valid, win_ready,
    input  in_ready, win_data, win_valid, count
  );

  modport slave (
    input  in_data, in_valid, win_ready,
    output in_ready, win_data, win_valid, count
  );
endinterface

// File: rtl/window_byte_fifo.sv
// Byte-granular sliding-window FIFO: word writes, strided
// window reads, optional zero left-padding at row start.
module window_byte_fifo #(
  parameter int IN_BYTES  = 8,
  parameter int WIN_BYTES = 3,
  parameter int DEPTH     = 16,
  parameter int PAD_BYTES = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       row_clear,
  input  logic [1:0] stride,
  input  logic       pad_en,
  window_byte_fifo_if.slave bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int SW = $clog2(WIN_BYTES + 1);

  localparam logic [PW:0]   DEP_W  = (PW+1)'(DEPTH);
  localparam logic [PW:0]   IN_W   = (PW+1)'(IN_BYTES);
  localparam logic [CW-1:0] IN_C   = CW'(IN_BYTES);
  localparam logic [CW-1:0] WIN_C  = CW'(WIN_BYTES);
  localparam logic [CW-1:0] ROOM_C = CW'(DEPTH - IN_BYTES);
  localparam logic [CW-1:0] PAD_C  = CW'(PAD_BYTES);
  localparam logic [PW-1:0] PAD_P  = PW'(PAD_BYTES);

  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic [SW-1:0] stride_q;
  logic [SW-1:0] stride_in;
  logic          clr;
  logic          push;
  logic          pop;
  logic [PW-1:0] wr_idx [IN_BYTES];
  logic [PW-1:0] rd_idx [WIN_BYTES];

  // Sum stays below 2*DEPTH, so one conditional subtract wraps it.
  function automatic logic [PW-1:0] add_mod(
    input logic [PW-1:0] p,
    input logic [PW:0]   d
  );
    logic [PW:0] s;
    s = {1'b0, p} + d;
    if (s >= DEP_W) s = s - DEP_W;
    return s[PW-1:0];
  endfunction

  always_comb begin
    stride_in = SW'(1);
    if (stride != 2'd0) begin
      if (int'(stride) > WIN_BYTES) stride_in = SW'(WIN_BYTES);
      else stride_in = SW'(stride);
    end
  end

  assign clr           = start | row_clear;
  assign bus.in_ready  = (cnt <= ROOM_C);
  assign bus.win_valid = (cnt >= WIN_C);
  assign bus.count     = cnt;
  assign push          = bus.in_valid & bus.in_ready & ~clr;
  assign pop           = bus.win_valid & bus.win_ready & ~clr;

  always_comb begin
    for (int i = 0; i < IN_BYTES; i++)
      wr_idx[i] = add_mod(wr_ptr, (PW+1)'(i));
    for (int i = 0; i < WIN_BYTES; i++)
      rd_idx[i] = add_mod(rd_ptr, (PW+1)'(i));
  end

  always_comb begin
    bus.win_data = '0;
    for (int i = 0; i < WIN_BYTES; i++)
      bus.win_data[8*i +: 8] = mem[rd_idx[i]];
  end

  always_comb begin
    cnt_nxt = cnt;
    if (push) cnt_nxt = cnt_nxt + IN_C;
    if (pop)  cnt_nxt = cnt_nxt - CW'(stride_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      cnt      <= '0;
      stride_q <= SW'(1);
    end else if (clr) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      rd_ptr   <= '0;
      stride_q <= stride_in;
      wr_ptr   <= pad_en ? PAD_P : '0;
      cnt      <= pad_en ? PAD_C : '0;
    end else begin
      if (push) begin
        for (int i = 0; i < IN_BYTES; i++)
          mem[wr_idx[i]] <= bus.in_data[8*i +: 8];
        wr_ptr <= add_mod(wr_ptr, IN_W);
      end
      if (pop) rd_ptr <= add_mod(rd_ptr, (PW+1)'(stride_q));
      cnt <= cnt_nxt;
    end
  end
endmodule

// File: tb/tb_window_byte_fifo.sv
// Directed bench for window_byte_fifo with default parameters:
// padding, strides, backpressure, wrap, row_clear and reset.
module tb_window_byte_fifo;
  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       row_clear;
  logic [1:0] stride;
  logic       pad_en;
  int         passed = 0;
  int         total  = 0;

  localparam logic [63:0] W1 = 64'h0807060504030201;
  localparam logic [63:0] W2 = 64'h100f0e0d0c0b0a09;
  localparam logic [63:0] W3 = 64'h1817161514131211;

  window_byte_fifo_if #(.IN_BYTES(8), .WIN_BYTES(3), .DEPTH(16)) bus ();

  window_byte_fifo #(
    .IN_BYTES(8), .WIN_BYTES(3), .DEPTH(16), .PAD_BYTES(1)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .row_clear(row_clear),
    .stride(stride), .pad_en(pad_en), .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; row_clear = 1'b0;
    stride = 2'd1; pad_en = 1'b0;
    bus.in_data = '0; bus.in_valid = 1'b0; bus.win_ready = 1'b0;
    step(); step();
    chk("rst_count", 64'(bus.count), 64'd0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_win_valid", 64'(bus.win_valid), 64'd0);
    chk("rst_win_data", 64'(bus.win_data), 64'd0);
    reset = 1'b0;

    // pad, stride 1
    start = 1'b1; pad_en = 1'b1; stride = 2'd1; step(); start = 1'b0;
    chk("pad_start_count", 64'(bus.count), 64'd1);
    bus.in_data = W1; bus.in_valid = 1'b1; step(); bus.in_valid = 1'b0;
    chk("pad_push_count", 64'(bus.count), 64'd9);
    chk("pad_push_valid", 64'(bus.win_valid), 64'd1);
    chk("pad_push_win", 64'(bus.win_data), 64'h020100);
    bus.win_ready = 1'b1; step(); bus.win_ready = 1'b0;
    chk("pad_pop_win", 64'(bus.win_data), 64'h030201);
    chk("pad_pop_count", 64'(bus.count), 64'd8);

    // stride 2, no pad
    start = 1'b1; pad_en = 1'b0; stride = 2'd2; step(); start = 1'b0;
    chk("s2_start_count", 64'(bus.count), 64'd0);
    bus.in_data = W1; bus.in_valid = 1'b1; step(); bus.in_valid = 1'b0;
    chk("s2_count0", 64'(bus.count), 64'd8);
    chk("s2_win0", 64'(bus.win_data), 64'h030201);
    bus.win_ready = 1'b1; step();
    chk("s2_win1", 64'(bus.win_data), 64'h050403);
    chk("s2_count1", 64'(bus.count), 64'd6);
    step();
    chk("s2_win2", 64'(bus.win_data), 64'h070605);
    chk("s2_count2", 64'(bus.count), 64'd4);
    step();
    chk("s2_count3", 64'(bus.count), 64'd2);
    chk("s2_valid3", 64'(bus.win_valid), 64'd0);
    step();
    chk("s2_no_underflow", 64'(bus.count), 64'd2);
    bus.win_ready = 1'b0;

    // full and backpressure
    start = 1'b1; pad_en = 1'b0; stride = 2'd1; step(); start = 1'b0;
    bus.in_data = W1; bus.in_valid = 1'b1; step();
    chk("full_count8", 64'(bus.count), 64'd8);
    chk("full_ready8", 64'(bus.in_ready), 64'd1);
    bus.in_data = W2; step();
    chk("full_count16", 64'(bus.count), 64'd16);
    chk("full_ready16", 64'(bus.in_ready), 64'd0);
    bus.in_data = W3; bus.win_ready = 1'b1;
    repeat (7) step();
    chk("bp_count9", 64'(bus.count), 64'd9);
    chk("bp_ready9", 64'(bus.in_ready), 64'd0);
    chk("bp_win9", 64'(bus.win_data), 64'h0a0908);
    step(); bus.win_ready = 1'b0;
    chk("bp_count8", 64'(bus.count), 64'd8);
    chk("bp_ready8", 64'(bus.in_ready), 64'd1);
    step(); bus.in_valid = 1'b0;
    chk("bp_accept_count", 64'(bus.count), 64'd16);
    chk("bp_accept_win", 64'(bus.win_data), 64'h0b0a09);
    bus.win_ready = 1'b1; repeat (8) step(); bus.win_ready = 1'b0;
    chk("bp_held_count", 64'(bus.count), 64'd8);
    chk("bp_held_word", 64'(bus.win_data), 64'h131211);

    // simultaneous push/pop and pointer wrap
    start = 1'b1; pad_en = 1'b0; stride = 2'd2; step(); start = 1'b0;
    bus.in_data = W1; bus.in_valid = 1'b1; step();
    bus.in_data = W2; step(); bus.in_valid = 1'b0;
    bus.win_ready = 1'b1; repeat (4) step();
    chk("wrap_pre_count", 64'(bus.count), 64'd8);
    bus.in_data = W3; bus.in_valid = 1'b1; step(); bus.in_valid = 1'b0;
    chk("wrap_pushpop_count", 64'(bus.count), 64'd14);
    chk("wrap_win_a", 64'(bus.win_data), 64'h0d0c0b);
    step();
    chk("wrap_win_b", 64'(bus.win_data), 64'h0f0e0d);
    chk("wrap_count_b", 64'(bus.count), 64'd12);
    step();
    chk("wrap_win_seam", 64'(bus.win_data), 64'h11100f);
    chk("wrap_count_seam", 64'(bus.count), 64'd10);
    step();
    chk("wrap_win_c", 64'(bus.win_data), 64'h131211);
    step();
    chk("wrap_win_d", 64'(bus.win_data), 64'h151413);
    chk("wrap_count_d", 64'(bus.count), 64'd6);
    bus.win_ready = 1'b0;

    // row_clear mid-row
    start = 1'b1; pad_en = 1'b1; stride = 2'd1; step(); start = 1'b0;
    bus.in_data = W1; bus.in_valid = 1'b1; step(); bus.in_valid = 1'b0;
    bus.win_ready = 1'b1; repeat (4) step(); bus.win_ready = 1'b0;
    chk("rc_pre_count", 64'(bus.count), 64'd5);
    row_clear = 1'b1; pad_en = 1'b1; bus.in_data = W2;
    bus.in_valid = 1'b1; bus.win_ready = 1'b1; step();
    row_clear = 1'b0; bus.in_valid = 1'b0; bus.win_ready = 1'b0;
    chk("rc_count", 64'(bus.count), 64'd1);
    chk("rc_valid", 64'(bus.win_valid), 64'd0);
    chk("rc_ready", 64'(bus.in_ready), 64'd1);
    chk("rc_cleared", 64'(bus.win_data), 64'd0);
    bus.in_data = W1; bus.in_valid = 1'b1; step(); bus.in_valid = 1'b0;
    chk("rc_pad_byte", 64'(bus.win_data[7:0]), 64'h00);
    chk("rc_win", 64'(bus.win_data), 64'h020100);
    chk("rc_count9", 64'(bus.count), 64'd9);

    // reset mid-stream, then stride 0 acts as 1
    start = 1'b1; pad_en = 1'b0; stride = 2'd1; step(); start = 1'b0;
    bus.in_data = W1; bus.in_valid = 1'b1; step(); bus.in_valid = 1'b0;
    bus.win_ready = 1'b1; repeat (4) step(); bus.win_ready = 1'b0;
    bus.in_data = W2; bus.in_valid = 1'b1; step(); bus.in_valid = 1'b0;
    chk("mr_pre_count", 64'(bus.count), 64'd12);
    chk("mr_pre_valid", 64'(bus.win_valid), 64'd1);
    reset = 1'b1; step(); reset = 1'b0;
    chk("mr_count", 64'(bus.count), 64'd0);
    chk("mr_valid", 64'(bus.win_valid), 64'd0);
    chk("mr_ready", 64'(bus.in_ready), 64'd1);
    chk("mr_win", 64'(bus.win_data), 64'd0);
    start = 1'b1; stride = 2'd0; step(); start = 1'b0;
    bus.in_data = W1; bus.in_valid = 1'b1; step(); bus.in_valid = 1'b0;
    bus.win_ready = 1'b1; step(); bus.win_ready = 1'b0;
    chk("s0_win", 64'(bus.win_data), 64'h040302);
    chk("s0_count", 64'(bus.count), 64'd7);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
